quad_one_to_two_demux: RTL and testbench
========================================

# quad_one_to_two_demux

Registered 1-to-2 demultiplexer: routes a 4-bit input stream to output channel A or B based on a select line. Each output has a one-entry buffer with valid/ready flow control. It is the receive-side counterpart of the quad 2-to-1 multiplexer, splitting a shared 4-bit path back into two destinations. An active-high disable input gates both outputs to zero, and per-channel transfer counters support bring-up.

## Interface
Parameters:
- WIDTH, 4, data width of every channel
- CNT_W, 8, width of each per-channel transfer counter

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- in_data  in  WIDTH  input word
- in_valid  in  1  input word present
- in_ready  out  1  block accepts the word this cycle
- S  in  1  destination select, sampled with the input word: 0 → A, 1 → B
- E  in  1  disable, active-high
- a_data  out  WIDTH  channel A word
- a_valid  out  1  channel A word present
- a_ready  in  1  channel A consumer accepts
- b_data  out  WIDTH  channel B word
- b_valid  out  1  channel B word present
- b_ready  in  1  channel B consumer accepts
- a_count  out  CNT_W  completed A output transfers, modulo 2^CNT_W
- b_count  out  CNT_W  completed B output transfers, modulo 2^CNT_W

## Operation
- Each channel holds one slot with two states, EMPTY and FULL.
- Accept: in_valid & in_ready. The word is written into the slot selected by S, and that slot becomes FULL.
- in_ready = ~E & (selected slot EMPTY | selected slot draining this cycle).
  - in_ready depends combinationally on S, E, and the selected slot's ready. It does not depend on in_valid.
- Drain: x_valid & x_ready. The slot goes to EMPTY unless it is refilled in the same cycle, in which case it stays FULL with the new word.
- x_valid = slot FULL & ~E.
- x_data = slot word when x_valid, else all zeros. Data is gated to zero while disabled, matching the multiplexer convention.
- E = 1:
  - no accepts and no drains;
  - slot contents and counters are retained;
  - outputs resume unchanged the cycle after E returns to 0.
- The unselected slot is unaffected by an accept. Both slots may drain in the same cycle.
- Counters increment by 1 on each drain of their channel and wrap from 2^CNT_W−1 to 0.

## Timing
- Reset values: a_valid = b_valid = 0, a_data = b_data = 0, both slots EMPTY, a_count = b_count = 0.
- in_ready is 1 after reset when E = 0.
- rst overrides every other input in the same cycle:
  - a pending accept or drain is discarded;
  - counters are not incremented.
- Latency: a word accepted at edge N is visible on x_data/x_valid from edge N onward, i.e. one cycle after being presented.
- Throughput: one word per cycle sustained to a single channel while its consumer holds ready = 1.
- Backpressure: with a slot FULL and x_ready = 0, in_ready = 0 for inputs selecting that slot. Inputs selecting the other slot are still accepted.
- x_data and x_valid stay stable while x_valid & ~x_ready (valid/ready hold rule), unless E rises.
- Changing S without an accept has no effect on state.

## Structure
- Shared package quad_demux_pkg:
  - WIDTH_DEFAULT = 4
  - SEL_A = 1'b0 and SEL_B = 1'b1
  - slot state enum {SLOT_EMPTY, SLOT_FULL}
- Sub-module demux_slot, instantiated twice:
  - one-entry buffer with load, drain, and gate (E) inputs;
  - owns its state register, word register, and transfer counter.
- Top level: select decode, in_ready logic, output gating.

## Test plan
- Reset, E = 0, S = 0, in_data = 4'hA, in_valid = 1, a_ready = 1 for one cycle → next cycle a_valid = 1, a_data = 4'hA; a_count reaches 1 one cycle later; b_valid stays 0.
- a_ready = 0, two back-to-back A words 4'h3 then 4'h5 → first accepted, in_ready = 0 on the second; a_data holds 4'h3; raising a_ready delivers 4'h3 then 4'h5.
- Slot A full and stalled, then S = 1 with 4'hC → accepted immediately; b_valid = 1, b_data = 4'hC while A still holds its word.
- Slot A FULL, then E = 1 for 3 cycles → a_valid = 0, a_data = 0, in_ready = 0, a_count unchanged; after E = 0, the original word reappears on a_data.
- 256 drains on B with CNT_W = 8 → b_count wraps to 0; a_count unaffected.
- rst asserted mid-stream with both slots FULL and readies high → next cycle both valids 0, data 0, counts 0, no count increment.

Source files
------------

// File: rtl/quad_demux_pkg.sv
// quad_demux_pkg: shared constants and slot state type for the quad 1-to-2 demultiplexer.
package quad_demux_pkg;
    localparam int WIDTH_DEFAULT = 4;
    localparam int CNT_W_DEFAULT = 8;
    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;
    typedef enum logic {SLOT_EMPTY, SLOT_FULL} slot_state_t;
endpackage

// File: rtl/quad_one_to_two_demux_slot.sv
// demux_slot: one-entry output buffer with its own transfer counter.
module demux_slot
    import quad_demux_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT,
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             gate,
    input  logic             ready,
    output logic             full,
    output logic             drain,
    output logic [WIDTH-1:0] word,
    output logic [CNT_W-1:0] count
);
    slot_state_t state;
    assign full  = state == SLOT_FULL;
    assign drain = full & ~gate & ready;
    // A load in the same cycle as a drain keeps the slot FULL with the new word.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= SLOT_EMPTY;
            word  <= '0;
            count <= '0;
        end else begin
            if (load) begin
                state <= SLOT_FULL;
                word  <= load_data;
            end else if (drain) begin
                state <= SLOT_EMPTY;
            end
            if (drain) count <= count + CNT_W'(1);
        end
    end
endmodule

// File: rtl/quad_one_to_two_demux.sv
// quad_one_to_two_demux: routes a valid/ready input stream to one of two buffered channels.
module quad_one_to_two_demux
    import quad_demux_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT,
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             S,
    input  logic             E,
    output logic [WIDTH-1:0] a_data,
    output logic             a_valid,
    input  logic             a_ready,
    output logic [WIDTH-1:0] b_data,
    output logic             b_valid,
    input  logic             b_ready,
    output logic [CNT_W-1:0] a_count,
    output logic [CNT_W-1:0] b_count
);
    logic sel_b, accept;
    logic a_full, b_full, a_drain, b_drain;
    logic [WIDTH-1:0] a_word, b_word;
    assign sel_b    = S == SEL_B;
    assign in_ready = ~E & (sel_b ? (~b_full | b_drain) : (~a_full | a_drain));
    assign accept   = in_valid & in_ready;
    demux_slot #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_a (
        .clk(clk), .rst(rst), .load(accept & ~sel_b), .load_data(in_data),
        .gate(E), .ready(a_ready), .full(a_full), .drain(a_drain),
        .word(a_word), .count(a_count)
    );
    demux_slot #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_b (
        .clk(clk), .rst(rst), .load(accept & sel_b), .load_data(in_data),
        .gate(E), .ready(b_ready), .full(b_full), .drain(b_drain),
        .word(b_word), .count(b_count)
    );
    // Disabled outputs read as idle zeros while the slots keep their contents.
    assign a_valid = a_full & ~E;
    assign b_valid = b_full & ~E;
    assign a_data  = a_valid ? a_word : '0;
    assign b_data  = b_valid ? b_word : '0;
endmodule

// File: tb/tb_quad_one_to_two_demux.sv
// tb_quad_one_to_two_demux: directed vectors checked against a slot-occupancy model every cycle.
module tb_quad_one_to_two_demux;
    logic clk = 1'b0;
    logic rst, in_valid, in_ready, S, E, a_valid, a_ready, b_valid, b_ready;
    logic [3:0] in_data, a_data, b_data;
    logic [7:0] a_count, b_count;
    int checks = 0;
    int failures = 0;
    bit m_full[2];
    int m_word[2];
    int m_cnt[2];
    logic last_rdy;

    quad_one_to_two_demux #(.WIDTH(4), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .S(S), .E(E), .a_data(a_data), .a_valid(a_valid), .a_ready(a_ready),
        .b_data(b_data), .b_valid(b_valid), .b_ready(b_ready),
        .a_count(a_count), .b_count(b_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic compare_outputs(input bit en);
        chk("a_valid", int'(a_valid), (m_full[0] && !en) ? 1 : 0);
        chk("b_valid", int'(b_valid), (m_full[1] && !en) ? 1 : 0);
        chk("a_data", int'(a_data), (m_full[0] && !en) ? m_word[0] : 0);
        chk("b_data", int'(b_data), (m_full[1] && !en) ? m_word[1] : 0);
        chk("a_count", int'(a_count), m_cnt[0]);
        chk("b_count", int'(b_count), m_cnt[1]);
    endtask

    // One clock: drive inputs, check in_ready, advance model at the edge, check outputs after it.
    task automatic cycle(input bit v, input int d, input bit sel, input bit en,
                         input bit ar, input bit br, input bit r = 1'b0);
        bit exp_rdy, take;
        bit rd[2];
        rst = r; in_valid = v; in_data = 4'(d); S = sel; E = en; a_ready = ar; b_ready = br;
        rd[0] = ar; rd[1] = br;
        #1;
        exp_rdy = !en && (!m_full[sel] || rd[sel]);
        last_rdy = in_ready;
        chk("in_ready", int'(in_ready), int'(exp_rdy));
        take = v && exp_rdy;
        @(posedge clk);
        if (r) begin
            for (int c = 0; c < 2; c++) begin
                m_full[c] = 0; m_word[c] = 0; m_cnt[c] = 0;
            end
        end else begin
            for (int c = 0; c < 2; c++)
                if (m_full[c] && !en && rd[c]) begin
                    m_cnt[c] = (m_cnt[c] + 1) % 256;
                    m_full[c] = 0;
                end
            if (take) begin
                m_full[sel] = 1;
                m_word[sel] = d & 15;
            end
        end
        #1;
        compare_outputs(en);
    endtask

    initial begin
        rst = 1; in_valid = 0; in_data = 0; S = 0; E = 0; a_ready = 0; b_ready = 0;
        cycle(0, 0, 0, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 0, 0, 1);
        chk("reset_a_valid", int'(a_valid), 0);
        chk("reset_counts", int'({a_count, b_count}), 0);
        chk("reset_in_ready", int'(last_rdy), 1);
        // single word to A
        cycle(1, 4'hA, 0, 0, 1, 0);
        chk("t1_a_data", int'(a_data), 4'hA);
        chk("t1_a_valid", int'(a_valid), 1);
        cycle(0, 0, 0, 0, 1, 0);
        chk("t1_a_count", int'(a_count), 1);
        chk("t1_b_valid", int'(b_valid), 0);
        // backpressure on A
        cycle(1, 4'h3, 0, 0, 0, 0);
        cycle(1, 4'h5, 0, 0, 0, 0);
        chk("t2_stall_rdy", int'(last_rdy), 0);
        chk("t2_hold", int'(a_data), 4'h3);
        cycle(1, 4'h5, 0, 0, 1, 0);
        chk("t2_refill_rdy", int'(last_rdy), 1);
        chk("t2_second", int'(a_data), 4'h5);
        cycle(0, 0, 0, 0, 1, 0);
        chk("t2_count", int'(a_count), 3);
        // B accepted while A stalls
        cycle(1, 4'h7, 0, 0, 0, 0);
        cycle(1, 4'hC, 1, 0, 0, 0);
        chk("t3_b_data", int'(b_data), 4'hC);
        chk("t3_a_data", int'(a_data), 4'h7);
        // disable for three cycles
        for (int i = 0; i < 3; i++) cycle(1, 4'h9, 0, 1, 1, 1);
        chk("t4_rdy", int'(last_rdy), 0);
        chk("t4_a_data", int'(a_data), 0);
        chk("t4_a_count", int'(a_count), 3);
        cycle(0, 0, 0, 0, 0, 0);
        chk("t4_resume", int'(a_data), 4'h7);
        // 256 drains on B wrap its counter
        for (int i = 0; i < 255; i++) cycle(1, i, 1, 0, 0, 1);
        chk("t5_b_255", int'(b_count), 255);
        cycle(1, 4'h6, 1, 0, 0, 1);
        chk("t5_b_wrap", int'(b_count), 0);
        chk("t5_a_count", int'(a_count), 3);
        // reset mid-stream with both slots full
        cycle(1, 4'h1, 0, 0, 1, 1, 1);
        chk("t6_valids", int'({a_valid, b_valid}), 0);
        chk("t6_data", int'({a_data, b_data}), 0);
        chk("t6_counts", int'({a_count, b_count}), 0);
        // mixed traffic
        for (int i = 0; i < 300; i++)
            cycle(1'($urandom_range(0, 3) != 0), int'($urandom_range(0, 15)), 1'($urandom),
                  1'($urandom_range(0, 7) == 0), 1'($urandom), 1'($urandom),
                  1'($urandom_range(0, 63) == 0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
